// File: rtl/mag_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// mag_cmp_arbiter
//
// Shares one unsigned WIDTH-bit magnitude comparator among four requesters.
// A round-robin pointer picks the first valid requester at or above it
// (mod 4). The winner's operands are captured on the handshake edge, compared
// in the following cycle, and the one-hot gt/eq/lt result is presented on a
// valid/ready response port until the consumer takes it. Only one transaction
// is in flight at a time, so grants are at least three cycles apart.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst_n      in   1            synchronous active-low reset
//   req_valid  in   N_REQ        per-requester request valid
//   req_a      in   N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   N_REQ*WIDTH  operand B, same packing as req_a
//   req_ready  out  N_REQ        one-hot accept, only in IDLE for the winner
//   rsp_valid  out  1            result valid
//   rsp_ready  in   1            result consumer ready (sampled only in RESP)
//   rsp_id     out  2            requester that owns the result
//   rsp_gt     out  1            A >  B (unsigned)
//   rsp_eq     out  1            A == B
//   rsp_lt     out  1            A <  B (unsigned)
//   busy       out  1            high whenever the FSM is not in IDLE
//
// N_REQ is exposed as a parameter but the ID path is two bits wide, so the
// block is only meaningful with N_REQ = 4.
// -----------------------------------------------------------------------------
module mag_cmp_arbiter #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_id,
  output logic                   rsp_gt,
  output logic                   rsp_eq,
  output logic                   rsp_lt,
  output logic                   busy
);

  localparam int ID_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cur_id;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;

  // ---------------------------------------------------------------------------
  // Operand unpacking: one lane per requester.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_lane [N_REQ];
  logic [WIDTH-1:0] b_lane [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign a_lane[i] = req_a[i*WIDTH +: WIDTH];
    assign b_lane[i] = req_b[i*WIDTH +: WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: scan rr_ptr, rr_ptr+1, ... (wrapping) and take the
  // first valid requester. The 2-bit index wraps on its own.
  // ---------------------------------------------------------------------------
  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] scan_id;

  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    grant_found = 1'b0;
    grant_id    = '0;
    scan_id     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_id = rr_ptr + ID_W'(k);
      if (!grant_found && req_valid[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  // Accept is only offered while idle and out of reset, and only to the
  // winner; req_valid changes in CMP/RESP therefore cannot start anything.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  logic handshake;
  assign handshake = |(req_valid & req_ready);

  // ---------------------------------------------------------------------------
  // Shared comparator: a single WIDTH+1 subtract. The borrow gives A < B,
  // a zero difference gives A == B, and A > B is whatever is left, so the
  // three flags are one-hot by construction.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] diff_ext;
  logic           cmp_lt;
  logic           cmp_eq;
  logic           cmp_gt;

  assign diff_ext = {1'b0, op_a} - {1'b0, op_b};
  assign cmp_lt   = diff_ext[WIDTH];
  assign cmp_eq   = (diff_ext[WIDTH-1:0] == '0);
  assign cmp_gt   = !cmp_lt && !cmp_eq;

  // ---------------------------------------------------------------------------
  // Control FSM with registered response outputs.
  //   IDLE : wait for a handshake, capture operands and requester ID
  //   CMP  : latch the comparator result and raise rsp_valid
  //   RESP : hold the result until rsp_ready, then advance the pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // here sees the pre-edge value of every other one, like real flops.
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      // NOTE: the operand registers are cleared as well; they are a handful
      // of flops, not a memory array, and a known value keeps reset state
      // fully deterministic.
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_gt    <= 1'b0;
      rsp_eq    <= 1'b0;
      rsp_lt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // With nothing valid the pointer is left where it is.
          if (handshake) begin
            op_a   <= a_lane[grant_id];
            op_b   <= b_lane[grant_id];
            cur_id <= grant_id;
            state  <= CMP;
          end
        end

        CMP: begin
          rsp_gt    <= cmp_gt;
          rsp_eq    <= cmp_eq;
          rsp_lt    <= cmp_lt;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end

        RESP: begin
          // Flags drop together with rsp_valid so they are never seen
          // asserted without a valid response.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_gt    <= 1'b0;
            rsp_eq    <= 1'b0;
            rsp_lt    <= 1'b0;
            rr_ptr    <= rsp_id + ID_W'(1);
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mag_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mag_cmp_arbiter
//
// Directed, self-checking bench for mag_cmp_arbiter. Inputs are driven just
// after the falling edge and outputs are sampled 1 ns later, well away from
// the rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mag_cmp_arbiter;

  localparam int WIDTH = 16;
  localparam int N_REQ = 4;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_id;
  logic                   rsp_gt;
  logic                   rsp_eq;
  logic                   rsp_lt;
  logic                   busy;

  int total = 0;
  int bad   = 0;

  mag_cmp_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_eq    (rsp_eq),
    .rsp_lt    (rsp_lt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full cycle, ending 1 ns after the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, rsp_gt, rsp_eq, rsp_lt};
  endfunction

  // Expected order and {gt,eq,lt} for the all-valid round-robin run.
  logic [1:0] rr_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [2:0] rr_flags [5] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b100};

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // ---------------- reset state ----------------
    @(negedge clk);
    step();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id",    rsp_id,    0);
    check("rst_flags",     flags(),   0);
    check("rst_busy",      busy,      0);
    check("rst_req_ready", req_ready, 0);

    req_valid = '0;
    rst_n     = 1'b1;
    step();
    check("idle_no_req_busy",  busy,      0);
    check("idle_no_req_ready", req_ready, 0);

    // ---------------- single request ID 2, gt ----------------
    set_op(2, 16'h1234, 16'h1233);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    check("t1_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    #1;
    check("t1_cmp_busy",  busy,      1);
    check("t1_cmp_valid", rsp_valid, 0);
    check("t1_cmp_ready", req_ready, 0);
    step();
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_id",    rsp_id,    2);
    check("t1_flags",     flags(),   3'b100);
    step();
    check("t1_idle_valid", rsp_valid, 0);
    check("t1_idle_busy",  busy,      0);
    check("t1_idle_flags", flags(),   0);

    // ---------------- ID 0, equal (rr_ptr = 3 wraps to 0) ----------------
    set_op(0, 16'hFFFF, 16'hFFFF);
    req_valid = 4'b0001;
    #1;
    check("t2_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    step();
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_id",    rsp_id,    0);
    check("t2_flags",     flags(),   3'b010);
    step();

    // ---------------- ID 0, less (unsigned) ----------------
    set_op(0, 16'h0000, 16'hFFFF);
    req_valid = 4'b0001;
    #1;
    check("t3_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    step();
    check("t3_rsp_id", rsp_id,  0);
    check("t3_flags",  flags(), 3'b001);
    step();

    // ---------------- all four valid from reset ----------------
    rst_n     = 1'b0;
    req_valid = 4'hF;
    set_op(0, 16'h0005, 16'h0003);
    set_op(1, 16'h0003, 16'h0003);
    set_op(2, 16'h0001, 16'h0009);
    set_op(3, 16'h8000, 16'h7FFF);
    #1;
    check("rr_rst_ready", req_ready, 0);
    step();
    rst_n = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      check($sformatf("rr%0d_grant", n), req_ready, 4'(1) << rr_order[n]);
      step();
      check($sformatf("rr%0d_cmp_ready", n), req_ready, 0);
      step();
      check($sformatf("rr%0d_id", n),    rsp_id,  rr_order[n]);
      check($sformatf("rr%0d_flags", n), flags(), rr_flags[n]);
      if (n == 4) req_valid = '0;
      step();
    end

    // ---------------- backpressure on ID 1 (rr_ptr = 1) ----------------
    set_op(1, 16'h00FF, 16'h0100);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    check("bp_grant", req_ready, 4'b0010);
    step();
    req_valid = 4'hF;
    step();
    for (int n = 0; n < 5; n++) begin
      check($sformatf("bp%0d_valid", n), rsp_valid, 1);
      check($sformatf("bp%0d_id", n),    rsp_id,    1);
      check($sformatf("bp%0d_flags", n), flags(),   3'b001);
      check($sformatf("bp%0d_ready", n), req_ready, 0);
      check($sformatf("bp%0d_busy", n),  busy,      1);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_rel_valid", rsp_valid, 0);
    check("bp_rel_busy",  busy,      0);
    check("bp_rel_next",  req_ready, 4'b0100);
    req_valid = '0;
    #1;

    // ---------------- reset during RESP (ID 1, gt) ----------------
    set_op(1, 16'h000A, 16'h0002);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    check("ra_grant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    step();
    check("ra_rsp_id", rsp_id,  1);
    check("ra_flags",  flags(), 3'b100);
    rst_n = 1'b0;
    step();
    check("ra_valid", rsp_valid, 0);
    check("ra_flags0", flags(),  0);
    check("ra_busy",  busy,      0);
    // IDs 1 and 3 both ask; only a cleared pointer picks 1.
    set_op(1, 16'h0007, 16'h0007);
    req_valid = 4'b1010;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("ra_ptr0_grant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    step();
    check("ra_new_id",    rsp_id,  1);
    check("ra_new_flags", flags(), 3'b010);
    step();

    // ---------------- wrap: ID 3, then 0 and 3 (rr_ptr = 2) ----------------
    set_op(3, 16'h0001, 16'h0002);
    set_op(0, 16'h0009, 16'h0001);
    req_valid = 4'b1000;
    #1;
    check("wr_grant3", req_ready, 4'b1000);
    step();
    req_valid = 4'b1001;
    #1;
    check("wr_cmp_ready", req_ready, 0);
    step();
    check("wr_id3",    rsp_id,  3);
    check("wr_flags3", flags(), 3'b001);
    step();
    check("wr_grant0", req_ready, 4'b0001);
    step();
    req_valid = 4'b1000;
    step();
    check("wr_id0",    rsp_id,  0);
    check("wr_flags0", flags(), 3'b100);
    step();
    check("wr_grant3b", req_ready, 4'b1000);
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
